// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM state encoding and wait-counter width for mem_responder
package mem_responder_pkg;
    typedef enum logic [1:0] {MR_IDLE, MR_DATA, MR_FETCH} mr_state_e;
    localparam int MR_WAIT_W = 4;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: core <-> memory responder bus (fetch port + data port)
//   master (core): drives pcIn, dataAddr, dataWrite, dataWe, dataRe[, dataMask]
//   slave (responder): drives instr, ifValid, dataRead, memValid
//   dataMask exists only when MEM_BYTE_EN is defined
interface mem_responder_if;
    logic [31:0] pcIn;
    logic [31:0] instr;
    logic        ifValid;
    logic [31:0] dataAddr;
    logic [31:0] dataWrite;
    logic        dataWe;
    logic        dataRe;
    logic [31:0] dataRead;
    logic        memValid;
`ifdef MEM_BYTE_EN
    logic [3:0]  dataMask;
`endif
    modport master (
        output pcIn, dataAddr, dataWrite, dataWe, dataRe,
`ifdef MEM_BYTE_EN
        output dataMask,
`endif
        input  instr, ifValid, dataRead, memValid
    );
    modport slave (
        input  pcIn, dataAddr, dataWrite, dataWe, dataRe,
`ifdef MEM_BYTE_EN
        input  dataMask,
`endif
        output instr, ifValid, dataRead, memValid
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array: single-port synchronous-read (read-first) RAM of 2^AW 32-bit words with byte-lane write enables
//   clk, en (access), we (write), be[3:0] (lanes), addr, wdata -> rdata (valid the cycle after en)
module mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++)
                if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: arbitrates core fetch and data requests onto one RAM with WAIT_CYCLES wait states
//   clk, rst (sync, active-high); bus (mem_responder_if.slave) carries both core ports
//   optional feature: MEM_BYTE_EN adds bus.dataMask byte-lane store enables
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    mem_responder_if.slave bus
);
    localparam logic [MR_WAIT_W-1:0] WAIT_INIT = MR_WAIT_W'(WAIT_CYCLES);
    mr_state_e             state, state_n;
    logic [MR_WAIT_W-1:0]  wait_cnt;
    logic [ADDR_WIDTH-1:0] pc_idx, d_idx, cap_addr, fb_addr, ram_addr;
    logic [31:0]           fb_data, rd_q, ram_q;
    logic [3:0]            ram_be;
    logic fb_valid, ld_q, done, arb, data_done, fetch_done, bypass, fetch_hit;
    logic data_req, take_data, take_fetch, ram_en, ram_we;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pcIn[31:ADDR_WIDTH+2], bus.pcIn[1:0],
                                bus.dataAddr[31:ADDR_WIDTH+2], bus.dataAddr[1:0]};
    always_comb begin
        pc_idx     = bus.pcIn[ADDR_WIDTH+1:2];
        d_idx      = bus.dataAddr[ADDR_WIDTH+1:2];
        done       = state != MR_IDLE && wait_cnt == '0;
        data_done  = done && state == MR_DATA;
        fetch_done = done && state == MR_FETCH;
        arb        = state == MR_IDLE || done;
        // completing fetch is forwarded straight from the RAM so ifValid rises on the completion cycle
        bypass     = fetch_done && pc_idx == cap_addr;
        fetch_hit  = (fb_valid && pc_idx == fb_addr) || bypass;
        // the request being acknowledged this cycle is still visible; it must not be re-accepted
        data_req   = (bus.dataWe || bus.dataRe) && !data_done;
        take_data  = arb && data_req;
        take_fetch = arb && !data_req && !fetch_hit;
        state_n    = take_data ? MR_DATA : take_fetch ? MR_FETCH : arb ? MR_IDLE : state;
        ram_en     = take_data || take_fetch;
        ram_we     = take_data && bus.dataWe;
        ram_addr   = take_data ? d_idx : pc_idx;
`ifdef MEM_BYTE_EN
        ram_be     = bus.dataMask;
`else
        ram_be     = 4'hF;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MR_IDLE;
            wait_cnt <= '0;
            fb_valid <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            rd_q     <= '0;
            cap_addr <= '0;
            ld_q     <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= ram_en ? WAIT_INIT : (wait_cnt != '0 ? wait_cnt - 1'b1 : wait_cnt);
            if (ram_en) begin
                cap_addr <= ram_addr;
                ld_q     <= take_data && bus.dataRe;
            end
            if (fetch_done) begin
                fb_data  <= ram_q;
                fb_addr  <= cap_addr;
                fb_valid <= 1'b1;
            end
            // a store hitting the word being buffered (old or just-loaded) invalidates it
            if (ram_we && d_idx == (fetch_done ? cap_addr : fb_addr)) fb_valid <= 1'b0;
            if (data_done && ld_q) rd_q <= ram_q;
        end
    end
    mem_array #(.AW(ADDR_WIDTH)) u_mem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (bus.dataWrite),
        .rdata (ram_q)
    );
    assign bus.memValid = data_done;
    assign bus.dataRead = (data_done && ld_q) ? ram_q : rd_q;
    assign bus.ifValid  = fetch_hit;
    assign bus.instr    = bypass ? ram_q : fb_data;
endmodule
